addsub_seq_chunked: RTL and testbench
=====================================

Name: addsub_seq_chunked

Overview:
- Parametrised multi-cycle adder/subtractor. It computes a WIDTH-bit add or subtract one CHUNK-bit carry-lookahead slice per cycle, LSB slice first, with the carry rippled between slices through a register.
- Replaces the fixed 8-bit start/done adder in the function library. It adds width and chunk generalisation, subtract mode, carry/borrow-in, signed-overflow and zero flags, and valid/ready handshakes on both sides.
- Sits between the datapath controller and the accumulate/bias stages.

Parameters:
- WIDTH, 32, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits computed per cycle; CHUNK == WIDTH gives single-cycle compute.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = add, 1 = subtract.
- cin  in  1  carry-in when adding, borrow-in when subtracting.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- carry_out  out  1  carry out of MSB (subtract: 1 = no borrow).
- overflow  out  1  signed (two's-complement) overflow.
- zero  out  1  sum == 0.
- busy  out  1  operation in progress (CALC or DONE).

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. All state changes on the rising edge of clk.
- Reset (rst_n low at an edge):
  - state = IDLE, chunk index = 0.
  - sum = 0, carry_out = 0, overflow = 0, zero = 0, out_valid = 0, busy = 0.
  - Inputs are ignored while rst_n is low.
- in_ready = (state == IDLE), combinational from state.
- Derived constant: NUM_CHUNKS = WIDTH / CHUNK.
- State IDLE:
  - On in_valid && in_ready: latch a; latch b_eff = sub ? ~b : b.
  - Set carry register = sub ? ~cin : cin.
  - Set chunk index = 0, busy = 1, go to CALC.
  - Result: add gives a + b + cin; subtract gives a - b - cin.
- State CALC, per cycle for chunk k:
  - sum[k*CHUNK +: CHUNK] = CLA(a_k, b_eff_k, carry register).
  - Carry register is updated with the chunk carry-out.
  - On the last chunk (k == NUM_CHUNKS-1):
    - carry_out = chunk carry-out.
    - overflow = carry into MSB XOR carry out of MSB.
    - zero = (final sum == 0), including the chunk written this cycle.
    - out_valid = 1, go to DONE.
- Latency: out_valid rises exactly NUM_CHUNKS cycles after the accepting edge (4 for defaults, 1 when CHUNK == WIDTH).
- State DONE:
  - sum and all flags are held stable; in_ready = 0; in_valid is ignored.
  - On out_valid && out_ready: out_valid = 0, busy = 0, go to IDLE.
  - The next accept occurs no earlier than the following cycle.
- Prior sum bits may be partially overwritten during CALC. Outputs are meaningful only while out_valid = 1.
- Reset mid-CALC or mid-DONE aborts the operation: no out_valid pulse, outputs return to reset values.
- Illegal or unused state encoding returns to IDLE.
- Width rules:
  - All internal arithmetic is CHUNK+1 bits per slice; no truncation except the final WIDTH-bit sum.
  - Elaboration error if WIDTH % CHUNK != 0 or CHUNK < 1.

Decomposition:
- Shared package (function_pkg):
  - state encoding constants ST_IDLE, ST_CALC, ST_DONE.
  - a NUM_CHUNKS/index-width helper function (clog2 of NUM_CHUNKS, minimum 1).
- Sub-module cla_chunk, parametrised by CHUNK:
  - Combinational generate/propagate lookahead.
  - Inputs x, y, ci. Outputs s, co, c_msb (carry into the top bit, used for overflow).
  - Instantiated once and time-multiplexed across chunks.

Test Plan:
All scenarios use WIDTH=32, CHUNK=8 unless noted.
1. Add, a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, carry_out=0, overflow=0, zero=0. out_valid rises exactly 4 cycles after the accepting edge (checks inter-chunk carry).
2. Add, a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0, carry_out=1, zero=1, overflow=0. Then a=0x7FFFFFFF, b=1 -> sum=0x80000000, overflow=1, carry_out=0.
3. Subtract:
   - a=5, b=7, cin=0 -> sum=0xFFFFFFFE, carry_out=0, overflow=0.
   - a=0x80000000, b=1 -> sum=0x7FFFFFFF, carry_out=1, overflow=1.
   - a=9, b=4, cin=1 -> sum=4.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling in_valid with new operands -> sum and flags stable, in_ready=0, busy=1, no new accept. Assert out_ready -> IDLE next cycle, then back-to-back accept succeeds.
5. Reset: drive rst_n low for one edge during CALC chunk 2 -> out_valid never pulses, all outputs 0, in_ready=1 after release. Next operation 3+4 -> 7.
6. Config CHUNK=32 (and CHUNK=4): randomised 1000 operations vs. reference model. Latency is 1 for CHUNK=32 and 8 for CHUNK=4; all results and flags must match.

Source files
------------

// File: rtl/addsub_seq_chunked_pkg.sv
// Shared types and helpers for the chunked sequential adder/subtractor.
package addsub_seq_chunked_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int unsigned num_chunks(input int unsigned width, input int unsigned chunk);
        return (chunk == 0) ? 1 : width / chunk;
    endfunction

    // Chunk index register width; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned width, input int unsigned chunk);
        int unsigned n;
        n = num_chunks(width, chunk);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addsub_seq_chunked_if.sv
// Operand/result handshake bundle for addsub_seq_chunked.
interface addsub_seq_chunked_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, zero, busy
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, zero, busy
    );
endinterface

// File: rtl/addsub_seq_chunked_cla_chunk.sv
// One CHUNK-bit carry-lookahead slice; c_msb is the carry into the top bit.
module cla_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;
    logic             acc;
    logic             pp;

    assign g = x & y;
    assign p = x ^ y;

    // Each carry is the flat OR of generate terms gated by the propagate run above them.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        pp   = 1'b0;
        c[0] = ci;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int unsigned j = i; j > 0; j--) begin
                acc = acc | (pp & g[j-1]);
                pp  = pp & p[j-1];
            end
            c[i+1] = acc | (pp & ci);
        end
    end

    assign s     = p ^ c[CHUNK-1:0];
    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/addsub_seq_chunked.sv
// Multi-cycle WIDTH-bit add/subtract, one CLA chunk per cycle, LSB chunk first.
module addsub_seq_chunked
    import addsub_seq_chunked_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    addsub_seq_chunked_if.slave bus
);
    localparam int unsigned SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
    localparam int unsigned NUM_CHUNKS = num_chunks(WIDTH, SAFE_CHUNK);
    localparam int unsigned IW         = idx_width(WIDTH, SAFE_CHUNK);

    if (CHUNK < 1 || (WIDTH % SAFE_CHUNK) != 0) begin : g_bad_cfg
        $error("addsub_seq_chunked: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_out_q;
    logic             overflow_q;
    logic             zero_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_k;
    logic [CHUNK-1:0] b_k;
    logic [CHUNK-1:0] s_k;
    logic             co_k;
    logic             cm_k;
    logic [WIDTH-1:0] next_sum;
    logic             last;

    // Shifts rather than variable part-selects keep the chunk mux index-width clean.
    always_comb begin
        base     = 32'(idx) * SAFE_CHUNK;
        a_k      = CHUNK'(a_q >> base);
        b_k      = CHUNK'(b_q >> base);
        next_sum = (sum_q & ~({{(WIDTH-CHUNK){1'b0}}, {CHUNK{1'b1}}} << base))
                 | ({{(WIDTH-CHUNK){1'b0}}, s_k} << base);
        last     = (idx == IW'(NUM_CHUNKS - 1));
    end

    cla_chunk #(.CHUNK(CHUNK)) u_cla (
        .x     (a_k),
        .y     (b_k),
        .ci    (carry_q),
        .s     (s_k),
        .co    (co_k),
        .c_msb (cm_k)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub ? ~bus.cin : bus.cin;
                        idx     <= '0;
                        busy_q  <= 1'b1;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    sum_q   <= next_sum;
                    carry_q <= co_k;
                    if (last) begin
                        carry_out_q <= co_k;
                        overflow_q  <= cm_k ^ co_k;
                        zero_q      <= (next_sum == '0);
                        out_valid_q <= 1'b1;
                        idx         <= '0;
                        state       <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    idx         <= '0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_addsub_seq_chunked.sv
// Scoreboard bench: directed checks on the 8-bit-chunk build, random sweep on 32- and 4-bit-chunk builds.
module tb_addsub_seq_chunked;

    typedef struct packed {
        logic [31:0] sum;
        logic        co;
        logic        ov;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_d, b_d;
    logic        sub_d, cin_d;
    logic        iv8, or8, ivr, orr;

    res_t q8[$];
    res_t q32[$];
    res_t q4[$];
    int   n_vec = 0;
    int   n_err = 0;

    addsub_seq_chunked_if #(.WIDTH(32)) bus8 ();
    addsub_seq_chunked_if #(.WIDTH(32)) bus32 ();
    addsub_seq_chunked_if #(.WIDTH(32)) bus4 ();

    assign bus8.a = a_d;   assign bus8.b = b_d;   assign bus8.sub = sub_d;  assign bus8.cin = cin_d;
    assign bus32.a = a_d;  assign bus32.b = b_d;  assign bus32.sub = sub_d; assign bus32.cin = cin_d;
    assign bus4.a = a_d;   assign bus4.b = b_d;   assign bus4.sub = sub_d;  assign bus4.cin = cin_d;
    assign bus8.in_valid = iv8;   assign bus8.out_ready = or8;
    assign bus32.in_valid = ivr;  assign bus32.out_ready = orr;
    assign bus4.in_valid = ivr;   assign bus4.out_ready = orr;

    addsub_seq_chunked #(.WIDTH(32), .CHUNK(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    addsub_seq_chunked #(.WIDTH(32), .CHUNK(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    addsub_seq_chunked #(.WIDTH(32), .CHUNK(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Signed-range and unsigned-borrow reference, independent of the chunked datapath.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input logic c);
        res_t        r;
        longint      sa, sb, cl, rs;
        logic [32:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cl = c ? 64'sd1 : 64'sd0;
        if (!s) begin
            u    = {1'b0, a} + {1'b0, b} + {32'd0, c};
            r.co = u[32];
            rs   = sa + sb + cl;
        end else begin
            u    = {1'b0, a} - {1'b0, b} - {32'd0, c};
            r.co = ({1'b0, a} >= ({1'b0, b} + {32'd0, c}));
            rs   = sa - sb - cl;
        end
        r.sum = u[31:0];
        r.ov  = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
        r.z   = (r.sum == 32'd0);
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic op8(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic c, input res_t exp);
        a_d = a; b_d = b; sub_d = s; cin_d = c;
        chk("in_ready_before_accept", bus8.in_ready, 1);
        iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        q8.push_back(exp);
        chk("busy_after_accept", bus8.busy, 1);
    endtask

    task automatic wait8(input string tag, input int lat_exp);
        int   lat;
        res_t e;
        lat = 0;
        while (bus8.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, lat_exp);
        if (q8.size() > 0) begin
            e = q8.pop_front();
            chk({tag, "_sum"},       bus8.sum,       e.sum);
            chk({tag, "_carry_out"}, bus8.carry_out, e.co);
            chk({tag, "_overflow"},  bus8.overflow,  e.ov);
            chk({tag, "_zero"},      bus8.zero,      e.z);
        end
    endtask

    task automatic release8();
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        chk("release_out_valid", bus8.out_valid, 0);
        chk("release_in_ready",  bus8.in_ready,  1);
        chk("release_busy",      bus8.busy,      0);
    endtask

    initial begin
        res_t e;
        int   l32, l4;
        iv8 = 0; or8 = 0; ivr = 0; orr = 0;
        a_d = '0; b_d = '0; sub_d = 0; cin_d = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        chk("reset_sum",       bus8.sum,       0);
        chk("reset_carry_out", bus8.carry_out, 0);
        chk("reset_overflow",  bus8.overflow,  0);
        chk("reset_zero",      bus8.zero,      0);
        chk("reset_out_valid", bus8.out_valid, 0);
        chk("reset_busy",      bus8.busy,      0);
        chk("reset_in_ready",  bus8.in_ready,  1);

        op8(32'h0000_00FF, 32'h0000_0001, 0, 0, '{32'h0000_0100, 1'b0, 1'b0, 1'b0});
        wait8("add_ff_1", 4);
        release8();

        op8(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1});
        wait8("add_wrap", 4);
        release8();
        op8(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0});
        wait8("add_ovf", 4);
        release8();

        op8(32'd5, 32'd7, 1, 0, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
        wait8("sub_5_7", 4);
        release8();
        op8(32'h8000_0000, 32'd1, 1, 0, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
        wait8("sub_ovf", 4);
        release8();
        op8(32'd9, 32'd4, 1, 1, '{32'd4, 1'b1, 1'b0, 1'b0});
        wait8("sub_borrow_in", 4);
        release8();

        op8(32'h1234_5678, 32'h1111_1111, 0, 0, '{32'h2345_6789, 1'b0, 1'b0, 1'b0});
        wait8("bp_first", 4);
        for (int i = 0; i < 5; i++) begin
            a_d = $urandom; b_d = $urandom; sub_d = i[0]; cin_d = i[1];
            iv8 = ~i[0];
            tick();
            chk("bp_sum_hold",  bus8.sum,       32'h2345_6789);
            chk("bp_co_hold",   bus8.carry_out, 0);
            chk("bp_valid",     bus8.out_valid, 1);
            chk("bp_in_ready",  bus8.in_ready,  0);
            chk("bp_busy",      bus8.busy,      1);
        end
        iv8 = 1'b0;
        release8();
        op8(32'hFFFF_FFFF, 32'h0000_0000, 0, 1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1});
        wait8("bp_back_to_back", 4);
        release8();

        a_d = 32'h0F0F_0F0F; b_d = 32'h0101_0101; sub_d = 0; cin_d = 0;
        iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_sum",       bus8.sum,       0);
        chk("abort_carry_out", bus8.carry_out, 0);
        chk("abort_overflow",  bus8.overflow,  0);
        chk("abort_zero",      bus8.zero,      0);
        chk("abort_busy",      bus8.busy,      0);
        chk("abort_in_ready",  bus8.in_ready,  1);
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_valid", bus8.out_valid, 0);
            tick();
        end
        op8(32'd3, 32'd4, 0, 0, '{32'd7, 1'b0, 1'b0, 1'b0});
        wait8("after_abort", 4);
        release8();

        for (int n = 0; n < 1000; n++) begin
            a_d = pick(); b_d = pick();
            sub_d = 1'($urandom_range(0, 1));
            cin_d = 1'($urandom_range(0, 1));
            e = model(a_d, b_d, sub_d, cin_d);
            q32.push_back(e);
            q4.push_back(e);
            ivr = 1'b1;
            tick();
            ivr = 1'b0;
            l32 = -1;
            l4  = -1;
            for (int t = 1; t <= 20 && (l32 < 0 || l4 < 0); t++) begin
                tick();
                if (bus32.out_valid === 1'b1 && l32 < 0) l32 = t;
                if (bus4.out_valid === 1'b1 && l4 < 0) l4 = t;
            end
            chk("c32_latency", l32, 1);
            chk("c4_latency",  l4,  8);
            e = q32.pop_front();
            chk("c32_sum",       bus32.sum,       e.sum);
            chk("c32_carry_out", bus32.carry_out, e.co);
            chk("c32_overflow",  bus32.overflow,  e.ov);
            chk("c32_zero",      bus32.zero,      e.z);
            e = q4.pop_front();
            chk("c4_sum",        bus4.sum,        e.sum);
            chk("c4_carry_out",  bus4.carry_out,  e.co);
            chk("c4_overflow",   bus4.overflow,   e.ov);
            chk("c4_zero",       bus4.zero,       e.z);
            orr = 1'b1;
            tick();
            orr = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
